// File: rtl/pipe_ctrl_gen_if.sv
// Pipeline control bus: stall requests, redirect and halt/resume controls in,
// per-stage hold/bubble, PC redirect, halt status and perf counters out.
//   master : the pipeline side that drives requests and consumes controls
//   slave  : pipe_ctrl_gen
interface pipe_ctrl_gen_if #(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [STAGES-1:0]     stallreq_in;
  logic                  jump_enable_in;
  logic [2:0]            jump_stage_in;
  logic [ADDR_WIDTH-1:0] jump_address_in;
  logic                  halt_req_in;
  logic                  resume_in;
  logic [STAGES-1:0]     stall_out;
  logic [STAGES-1:0]     bubble_out;
  logic                  pc_load_out;
  logic [ADDR_WIDTH-1:0] new_pc_out;
  logic                  halted_out;
  logic [CNT_WIDTH-1:0]  stall_cycles_out;
  logic [CNT_WIDTH-1:0]  flush_count_out;

  modport master (
    output stallreq_in, jump_enable_in, jump_stage_in, jump_address_in,
           halt_req_in, resume_in,
    input  stall_out, bubble_out, pc_load_out, new_pc_out, halted_out,
           stall_cycles_out, flush_count_out
  );

  modport slave (
    input  stallreq_in, jump_enable_in, jump_stage_in, jump_address_in,
           halt_req_in, resume_in,
    output stall_out, bubble_out, pc_load_out, new_pc_out, halted_out,
           stall_cycles_out, flush_count_out
  );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Pipeline hazard/redirect controller with drain-and-halt sequencing.
// Ports:
//   clk_in   : clock, rising edge
//   reset_in : asynchronous active-low reset
//   bus      : pipe_ctrl_gen_if.slave (stall requests, redirect, halt/resume
//              in; stall/bubble masks, PC redirect, halted, counters out)
// Stall/bubble/PC outputs are combinational (zero latency) and forced to 0
// while reset is asserted.
module pipe_ctrl_gen #(
  parameter int unsigned STAGES     = 5,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic           clk_in,
  input  logic           reset_in,
  pipe_ctrl_gen_if.slave bus
);
  localparam int unsigned DCNT_W = $clog2(STAGES);
  localparam logic [DCNT_W-1:0]    DRAIN_LOAD = DCNT_W'(STAGES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                state, state_nxt;
  logic [DCNT_W-1:0]     dcnt;
  logic [ADDR_WIDTH-1:0] resume_addr;
  logic                  resume_vld;
  logic [CNT_WIDTH-1:0]  stall_cnt, flush_cnt;

  logic [STAGES-1:0]     req_eff, hold, bub_pre, flush;
  logic                  hold_acc;
  logic [7:0]            hold_pad;
  logic                  any_req, in_range, accept;

  logic [STAGES-1:0]     stall_v, bubble_v;
  logic                  pc_load_v, halted_v;
  logic [ADDR_WIDTH-1:0] new_pc_v;

  // Hold mask: every stage at or below the highest requester holds.
  // DRAIN injects a permanent request at stage 0 to block fetch, which also
  // makes stage 1 take a bubble whenever stage 1 itself is not held.
  always_comb begin
    req_eff = bus.stallreq_in;
    if (state == DRAIN) req_eff[0] = 1'b1;
    hold     = '0;
    hold_acc = 1'b0;
    for (int j = int'(STAGES) - 1; j >= 0; j--) begin
      hold_acc = hold_acc | req_eff[j];
      hold[j]  = hold_acc;
    end
  end

  // Bubble goes into the first stage above the held region.
  always_comb begin
    bub_pre = '0;
    for (int j = 1; j < int'(STAGES); j++) bub_pre[j] = hold[j-1] & ~hold[j];
  end

  assign any_req  = |bus.stallreq_in;
  assign hold_pad = 8'(hold);
  assign in_range = 32'(bus.jump_stage_in) < STAGES;
  // A held resolving stage will re-present its redirect later.
  assign accept   = bus.jump_enable_in && in_range && !hold_pad[bus.jump_stage_in] &&
                    (state != HALTED);

  // Redirect squashes stages 1..jump_stage, overriding stall hold/bubble.
  always_comb begin
    flush = '0;
    for (int j = 1; j < int'(STAGES); j++)
      flush[j] = accept && (3'(j) <= bus.jump_stage_in);
  end

  // FSM state register
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state <= RUN;
    else           state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (bus.halt_req_in) state_nxt = DRAIN;
      DRAIN:   if (!any_req && (dcnt == DCNT_W'(1))) state_nxt = HALTED;
      HALTED:  if (bus.resume_in) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall_v   = '0;
    bubble_v  = '0;
    pc_load_v = 1'b0;
    new_pc_v  = '0;
    halted_v  = 1'b0;
    if (reset_in) begin
      case (state)
        RUN: begin
          stall_v   = hold & ~flush;
          bubble_v  = bub_pre | flush;
          pc_load_v = accept;
          if (accept) new_pc_v = bus.jump_address_in;
        end
        DRAIN: begin
          stall_v  = hold & ~flush;
          bubble_v = bub_pre | flush;
        end
        HALTED: begin
          stall_v  = '1;
          halted_v = 1'b1;
          if (bus.resume_in && resume_vld) begin
            pc_load_v = 1'b1;
            new_pc_v  = resume_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // Drain counter, pending resume target, saturating perf counters
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      dcnt        <= '0;
      resume_addr <= '0;
      resume_vld  <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (state == RUN && bus.halt_req_in)
        dcnt <= DRAIN_LOAD;
      else if (state == DRAIN && !any_req && dcnt != '0)
        dcnt <= dcnt - DCNT_W'(1);

      if (state == DRAIN && accept) begin
        resume_addr <= bus.jump_address_in;
        resume_vld  <= 1'b1;
      end else if (state == HALTED && bus.resume_in) begin
        resume_vld  <= 1'b0;
      end

      if (state != HALTED && any_req && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (accept && flush_cnt != CNT_MAX)
        flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.stall_out        = stall_v;
  assign bus.bubble_out       = bubble_v;
  assign bus.pc_load_out      = pc_load_v;
  assign bus.new_pc_out       = new_pc_v;
  assign bus.halted_out       = halted_v;
  assign bus.stall_cycles_out = stall_cnt;
  assign bus.flush_count_out  = flush_cnt;
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen (STAGES=5, 4-bit counters so that
// saturation is reachable quickly).
module tb_pipe_ctrl_gen;
  localparam int unsigned ST    = 5;
  localparam int unsigned AW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned COMBW = 2 * ST + 1 + AW;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_gen_if #(.STAGES(ST), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  pipe_ctrl_gen #(.STAGES(ST), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [ST-1:0] req;
    logic          je;
    logic [2:0]    js;
    logic [AW-1:0] ja;
    logic          halt;
    logic          res;
    logic [ST-1:0] es;
    logic [ST-1:0] eb;
    logic          ep;
    logic [AW-1:0] ea;
    logic          eh;   // DUT is in HALTED during this cycle
    logic          acc;  // redirect expected to be accepted
  } vec_t;

  typedef struct {
    string            name;
    logic [COMBW-1:0] val;
    logic             halted;
  } exp_t;

  exp_t          sb_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [CW-1:0] exp_sc, exp_fc;

  function automatic vec_t mk(input logic [ST-1:0] req, input logic je, input logic [2:0] js,
                              input logic [AW-1:0] ja, input logic halt, input logic res,
                              input logic [ST-1:0] es, input logic [ST-1:0] eb, input logic ep,
                              input logic [AW-1:0] ea, input logic eh, input logic acc);
    vec_t v;
    v.req = req; v.je = je; v.js = js; v.ja = ja; v.halt = halt; v.res = res;
    v.es = es; v.eb = eb; v.ep = ep; v.ea = ea; v.eh = eh; v.acc = acc;
    return v;
  endfunction

  // Drive one cycle of stimulus and queue its expected combinational result.
  task automatic apply(input vec_t v, input string nm);
    bus.stallreq_in     = v.req;
    bus.jump_enable_in  = v.je;
    bus.jump_stage_in   = v.js;
    bus.jump_address_in = v.ja;
    bus.halt_req_in     = v.halt;
    bus.resume_in       = v.res;
    sb_q.push_back('{nm, {v.es, v.eb, v.ep, v.ea}, v.eh});
    #2;
  endtask

  // Expected counter movement caused by the cycle just driven.
  task automatic account(input vec_t v);
    if (v.req != '0 && !v.eh && exp_sc != '1) exp_sc = exp_sc + CW'(1);
    if (v.acc && exp_fc != '1) exp_fc = exp_fc + CW'(1);
  endtask

  task automatic test_reset();
    exp_t e;
    logic [COMBW-1:0] got;
    rst_n = 1'b0;
    apply(mk(5'b00100, Y, 3'd2, 32'h80, Y, Y, '0, '0, N, '0, N, N), "reset");
    @(negedge clk);
    #2;
    e   = sb_q.pop_front();
    got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
    checks++;
    if (got !== e.val) begin failures++; $display("FAIL %s comb: got %h want %h", e.name, got, e.val); end
    checks++;
    if (bus.halted_out !== 1'b0) begin failures++; $display("FAIL reset halted: got %b want 0", bus.halted_out); end
    checks++;
    if (bus.stall_cycles_out !== '0) begin failures++; $display("FAIL reset stall_cnt: got %0d want 0", bus.stall_cycles_out); end
    checks++;
    if (bus.flush_count_out !== '0) begin failures++; $display("FAIL reset flush_cnt: got %0d want 0", bus.flush_count_out); end
    @(negedge clk);
    rst_n  = 1'b1;
    exp_sc = '0;
    exp_fc = '0;
  endtask

  task automatic test_stall();
    vec_t tv[$];
    exp_t e;
    logic [COMBW-1:0] got;
    tv.push_back(mk(5'b00000, N, 3'd0, '0, N, N, 5'b00000, 5'b00000, N, '0, N, N));
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(5'b00100, N, 3'd0, '0, N, N, 5'b00111, 5'b01000, N, '0, N, N));
    tv.push_back(mk(5'b00001, N, 3'd0, '0, N, N, 5'b00001, 5'b00010, N, '0, N, N));
    tv.push_back(mk(5'b10000, N, 3'd0, '0, N, N, 5'b11111, 5'b00000, N, '0, N, N));
    tv.push_back(mk(5'b01010, N, 3'd0, '0, N, N, 5'b01111, 5'b10000, N, '0, N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0, N, N, 5'b00000, 5'b00000, N, '0, N, N));
    foreach (tv[i]) begin
      apply(tv[i], "stall");
      e   = sb_q.pop_front();
      got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
      checks++;
      if (got !== e.val) begin failures++; $display("FAIL %s[%0d] comb: got %h want %h", e.name, i, got, e.val); end
      checks++;
      if (bus.stall_cycles_out !== exp_sc) begin failures++; $display("FAIL %s[%0d] stall_cnt: got %0d want %0d", e.name, i, bus.stall_cycles_out, exp_sc); end
      account(tv[i]);
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    vec_t tv[$];
    exp_t e;
    logic [COMBW-1:0] got;
    tv.push_back(mk(5'b00000, Y, 3'd2, 32'h80,   N, N, 5'b00000, 5'b00110, Y, 32'h80,   N, Y));
    tv.push_back(mk(5'b01000, Y, 3'd2, 32'h80,   N, N, 5'b01111, 5'b10000, N, '0,       N, N));
    tv.push_back(mk(5'b00000, Y, 3'd5, 32'h80,   N, N, 5'b00000, 5'b00000, N, '0,       N, N));
    tv.push_back(mk(5'b00010, Y, 3'd3, 32'h1234, N, N, 5'b00001, 5'b01110, Y, 32'h1234, N, Y));
    tv.push_back(mk(5'b00000, N, 3'd2, 32'h80,   N, N, 5'b00000, 5'b00000, N, '0,       N, N));
    tv.push_back(mk(5'b00000, Y, 3'd0, 32'h44,   N, N, 5'b00000, 5'b00000, Y, 32'h44,   N, Y));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,       N, N, 5'b00000, 5'b00000, N, '0,       N, N));
    foreach (tv[i]) begin
      apply(tv[i], "redirect");
      e   = sb_q.pop_front();
      got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
      checks++;
      if (got !== e.val) begin failures++; $display("FAIL %s[%0d] comb: got %h want %h", e.name, i, got, e.val); end
      checks++;
      if (bus.flush_count_out !== exp_fc) begin failures++; $display("FAIL %s[%0d] flush_cnt: got %0d want %0d", e.name, i, bus.flush_count_out, exp_fc); end
      checks++;
      if (bus.stall_cycles_out !== exp_sc) begin failures++; $display("FAIL %s[%0d] stall_cnt: got %0d want %0d", e.name, i, bus.stall_cycles_out, exp_sc); end
      account(tv[i]);
      @(negedge clk);
    end
  endtask

  // Halt latency: 4 drain cycles without stalls, 5 with one stall inserted.
  task automatic test_halt();
    vec_t tv[$];
    exp_t e;
    logic [COMBW-1:0] got;
    for (int r = 0; r < 2; r++) begin
      tv.push_back(mk(5'b00000, N, 3'd0, '0, Y, N, 5'b00000, 5'b00000, N, '0, N, N));
      for (int c = 1; c <= 4 + r; c++)
        tv.push_back(mk((r == 1 && c == 1) ? 5'b00001 : 5'b00000, N, 3'd0, '0, N, N,
                        5'b00001, 5'b00010, N, '0, N, N));
      for (int c = 0; c < 2; c++)
        tv.push_back(mk(5'b00100, Y, 3'd2, 32'h999, Y, N, 5'b11111, 5'b00000, N, '0, Y, N));
      tv.push_back(mk(5'b00000, N, 3'd0, '0, N, Y, 5'b11111, 5'b00000, N, '0, Y, N));
      tv.push_back(mk(5'b00000, N, 3'd0, '0, N, N, 5'b00000, 5'b00000, N, '0, N, N));
    end
    foreach (tv[i]) begin
      apply(tv[i], "halt");
      e   = sb_q.pop_front();
      got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
      checks++;
      if (got !== e.val) begin failures++; $display("FAIL %s[%0d] comb: got %h want %h", e.name, i, got, e.val); end
      checks++;
      if (bus.halted_out !== e.halted) begin failures++; $display("FAIL %s[%0d] halted: got %b want %b", e.name, i, bus.halted_out, e.halted); end
      checks++;
      if (bus.stall_cycles_out !== exp_sc) begin failures++; $display("FAIL %s[%0d] stall_cnt: got %0d want %0d", e.name, i, bus.stall_cycles_out, exp_sc); end
      checks++;
      if (bus.flush_count_out !== exp_fc) begin failures++; $display("FAIL %s[%0d] flush_cnt: got %0d want %0d", e.name, i, bus.flush_count_out, exp_fc); end
      account(tv[i]);
      @(negedge clk);
    end
  endtask

  // Redirects during DRAIN are latched (last wins) and replayed on resume.
  task automatic test_resume_redirect();
    vec_t tv[$];
    exp_t e;
    logic [COMBW-1:0] got;
    tv.push_back(mk(5'b00000, Y, 3'd1, 32'h40,  Y, N, 5'b00000, 5'b00010, Y, 32'h40,  N, Y));
    tv.push_back(mk(5'b00000, Y, 3'd2, 32'h100, N, N, 5'b00001, 5'b00110, N, '0,      N, Y));
    tv.push_back(mk(5'b00000, Y, 3'd2, 32'h200, N, N, 5'b00001, 5'b00110, N, '0,      N, Y));
    tv.push_back(mk(5'b00000, Y, 3'd0, 32'h777, N, N, 5'b00001, 5'b00010, N, '0,      N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, N, 5'b00001, 5'b00010, N, '0,      N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, Y, 5'b11111, 5'b00000, Y, 32'h200, Y, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      Y, N, 5'b00000, 5'b00000, N, '0,      N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, N, 5'b00001, 5'b00010, N, '0,      N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, Y, 5'b00001, 5'b00010, N, '0,      N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      Y, N, 5'b00001, 5'b00010, N, '0,      N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, N, 5'b00001, 5'b00010, N, '0,      N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, Y, 5'b11111, 5'b00000, N, '0,      Y, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, Y, 5'b00000, 5'b00000, N, '0,      N, N));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, N, 5'b00000, 5'b00000, N, '0,      N, N));
    foreach (tv[i]) begin
      apply(tv[i], "resume");
      e   = sb_q.pop_front();
      got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
      checks++;
      if (got !== e.val) begin failures++; $display("FAIL %s[%0d] comb: got %h want %h", e.name, i, got, e.val); end
      checks++;
      if (bus.halted_out !== e.halted) begin failures++; $display("FAIL %s[%0d] halted: got %b want %b", e.name, i, bus.halted_out, e.halted); end
      checks++;
      if (bus.flush_count_out !== exp_fc) begin failures++; $display("FAIL %s[%0d] flush_cnt: got %0d want %0d", e.name, i, bus.flush_count_out, exp_fc); end
      account(tv[i]);
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    vec_t v;
    exp_t e;
    logic [COMBW-1:0] got;
    v = mk(5'b00001, N, 3'd0, '0, N, N, 5'b00001, 5'b00010, N, '0, N, N);
    for (int i = 0; i < 20; i++) begin
      apply(v, "saturate");
      e   = sb_q.pop_front();
      got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
      checks++;
      if (got !== e.val) begin failures++; $display("FAIL %s[%0d] comb: got %h want %h", e.name, i, got, e.val); end
      checks++;
      if (bus.stall_cycles_out !== exp_sc) begin failures++; $display("FAIL %s[%0d] stall_cnt: got %0d want %0d", e.name, i, bus.stall_cycles_out, exp_sc); end
      account(v);
      @(negedge clk);
    end
    checks++;
    if (bus.stall_cycles_out !== 4'hf) begin failures++; $display("FAIL saturate final: got %0d want 15", bus.stall_cycles_out); end
  endtask

  // Reset mid-DRAIN drops the pending resume target as well.
  task automatic test_reset_mid_drain();
    vec_t tv[$];
    vec_t tp[$];
    exp_t e;
    logic [COMBW-1:0] got;
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      Y, N, 5'b00000, 5'b00000, N, '0, N, N));
    tv.push_back(mk(5'b00000, Y, 3'd2, 32'h300, N, N, 5'b00001, 5'b00110, N, '0, N, Y));
    tv.push_back(mk(5'b00000, N, 3'd0, '0,      N, N, 5'b00001, 5'b00010, N, '0, N, N));
    foreach (tv[i]) begin
      apply(tv[i], "predrain");
      e   = sb_q.pop_front();
      got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
      checks++;
      if (got !== e.val) begin failures++; $display("FAIL %s[%0d] comb: got %h want %h", e.name, i, got, e.val); end
      account(tv[i]);
      @(negedge clk);
    end
    bus.stallreq_in     = 5'b00100;
    bus.jump_enable_in  = 1'b1;
    bus.jump_stage_in   = 3'd1;
    bus.jump_address_in = 32'h55;
    #2;
    rst_n = 1'b0;
    #1;
    got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
    checks++;
    if (got !== '0) begin failures++; $display("FAIL midreset comb: got %h want 0", got); end
    checks++;
    if (bus.halted_out !== 1'b0) begin failures++; $display("FAIL midreset halted: got %b want 0", bus.halted_out); end
    checks++;
    if (bus.stall_cycles_out !== '0) begin failures++; $display("FAIL midreset stall_cnt: got %0d want 0", bus.stall_cycles_out); end
    checks++;
    if (bus.flush_count_out !== '0) begin failures++; $display("FAIL midreset flush_cnt: got %0d want 0", bus.flush_count_out); end
    @(negedge clk);
    #2;
    got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
    checks++;
    if (got !== '0) begin failures++; $display("FAIL midreset held comb: got %h want 0", got); end
    @(negedge clk);
    rst_n  = 1'b1;
    exp_sc = '0;
    exp_fc = '0;
    tp.push_back(mk(5'b00000, N, 3'd0, '0, N, N, 5'b00000, 5'b00000, N, '0, N, N));
    tp.push_back(mk(5'b00000, N, 3'd0, '0, Y, N, 5'b00000, 5'b00000, N, '0, N, N));
    for (int c = 0; c < 4; c++)
      tp.push_back(mk(5'b00000, N, 3'd0, '0, N, N, 5'b00001, 5'b00010, N, '0, N, N));
    tp.push_back(mk(5'b00000, N, 3'd0, '0, N, Y, 5'b11111, 5'b00000, N, '0, Y, N));
    tp.push_back(mk(5'b00000, N, 3'd0, '0, N, N, 5'b00000, 5'b00000, N, '0, N, N));
    foreach (tp[i]) begin
      apply(tp[i], "postreset");
      e   = sb_q.pop_front();
      got = {bus.stall_out, bus.bubble_out, bus.pc_load_out, bus.new_pc_out};
      checks++;
      if (got !== e.val) begin failures++; $display("FAIL %s[%0d] comb: got %h want %h", e.name, i, got, e.val); end
      checks++;
      if (bus.halted_out !== e.halted) begin failures++; $display("FAIL %s[%0d] halted: got %b want %b", e.name, i, bus.halted_out, e.halted); end
      checks++;
      if (bus.flush_count_out !== exp_fc) begin failures++; $display("FAIL %s[%0d] flush_cnt: got %0d want %0d", e.name, i, bus.flush_count_out, exp_fc); end
      account(tp[i]);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_halt();
    test_resume_redirect();
    test_saturation();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_gen.md
PIPE_CTRL_GEN -- requirements
Module: pipe_ctrl_gen

Interface
REQ-001 Parameter STAGES, default 5, number of pipeline stages (stage 0 = PC/IF, stage STAGES-1 = WB); legal range 3..8.
REQ-002 Parameter ADDR_WIDTH, default 32, width of redirect addresses.
REQ-003 Parameter CNT_WIDTH, default 16, width of performance counters.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 reset_in  input  1  reset, asynchronous, active-low.
REQ-006 stallreq_in  input  STAGES  bit i = stage i requests a hold this cycle.
REQ-007 jump_enable_in  input  1  redirect request from the resolving stage.
REQ-008 jump_stage_in  input  3  index of the stage issuing the redirect.
REQ-009 jump_address_in  input  ADDR_WIDTH  redirect target.
REQ-010 halt_req_in  input  1  one-cycle pulse requesting a pipeline drain and halt.
REQ-011 resume_in  input  1  one-cycle pulse leaving the HALTED state.
REQ-012 stall_out  output  STAGES  bit i = hold the stage i register.
REQ-013 bubble_out  output  STAGES  bit i = load a NOP into the stage i register.
REQ-014 pc_load_out  output  1  PC loads new_pc_out this cycle.
REQ-015 new_pc_out  output  ADDR_WIDTH  PC redirect value.
REQ-016 halted_out  output  1  pipeline drained and frozen.
REQ-017 stall_cycles_out  output  CNT_WIDTH  count of cycles with any stall request.
REQ-018 flush_count_out  output  CNT_WIDTH  count of accepted redirects.

Function
REQ-019 Stall: with k = highest i where stallreq_in[i]=1, stall_out[j]=1 for all j<=k; bubble_out[k+1]=1 when k+1<STAGES; no request -> stall_out=0, bubble_out=0 (RUN state); combinational, zero latency.
REQ-020 A redirect is accepted only when jump_enable_in=1, jump_stage_in<STAGES and stall_out[jump_stage_in]=0; otherwise ignored (the held stage re-presents it).
REQ-021 Accepted redirect in RUN: pc_load_out=1, new_pc_out=jump_address_in, bubble_out[j]=1 and stall_out[j]=0 for 1<=j<=jump_stage_in, same cycle; stages above jump_stage_in unaffected.
REQ-022 Redirect flush overrides a stall-generated bubble or hold in the same younger stages.
REQ-023 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-024 RUN -> DRAIN on halt_req_in=1; a drain counter loads STAGES-1.
REQ-025 DRAIN: stall_out[0]=1, bubble_out[1]=1 every cycle (fetch blocked); stall rules of REQ-019 still apply above stage 0; counter decrements only on cycles with stallreq_in=0; DRAIN -> HALTED when counter reaches 0 on a decrement.
REQ-026 Accepted redirect in DRAIN: pc_load_out=0, flush per REQ-021, target latched into a resume register with a resume-valid flag set; later redirects overwrite it.
REQ-027 HALTED: stall_out all 1, bubble_out all 0, halted_out=1, redirects ignored, halt_req_in ignored.
REQ-028 HALTED -> RUN on resume_in=1; in that cycle pc_load_out=1 with new_pc_out=resume register if resume-valid, else pc_load_out=0; resume-valid cleared.
REQ-029 resume_in outside HALTED is ignored; halt_req_in outside RUN is ignored; simultaneous halt_req_in and accepted redirect in RUN: redirect executes per REQ-021 and FSM enters DRAIN.
REQ-030 stall_cycles_out increments each cycle with any stallreq_in bit set, saturating at all-ones; flush_count_out increments per accepted redirect, saturating; both frozen in HALTED.
REQ-031 new_pc_out = 0 whenever pc_load_out=0.

Reset
REQ-032 reset_in=0 asynchronously forces: state RUN, drain counter 0, resume register 0, resume-valid 0, both counters 0, halted_out 0; while asserted all outputs 0.
REQ-033 Reset asserted mid-DRAIN or in HALTED abandons the operation; first cycle after release behaves as RUN with no pending resume.

Verification
REQ-034 STAGES=5, stallreq_in=5'b00100 -> stall_out=5'b00111, bubble_out=5'b01000, stall_cycles_out +1 per cycle.
REQ-035 jump_enable_in=1, jump_stage_in=2, address 0x80, no stall -> pc_load_out=1, new_pc_out=0x80, bubble_out=5'b00110, flush_count_out=1.
REQ-036 jump_stage_in=2 with stallreq_in=5'b01000 -> redirect ignored, pc_load_out=0, flush_count_out unchanged.
REQ-037 halt_req_in pulse, no stalls -> halted_out=1 exactly 4 cycles later; one stall cycle inserted during DRAIN -> 5 cycles; stall_out=5'b11111 while halted.
REQ-038 Redirect to 0x200 from stage 2 during DRAIN, then resume_in in HALTED -> pc_load_out=1, new_pc_out=0x200 in resume cycle; second resume without redirect -> pc_load_out=0.
REQ-039 Counter at all-ones plus another stall cycle -> stays all-ones; reset_in low mid-DRAIN -> all outputs 0 immediately, RUN after release.
